// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions.
// Branch funct3 encodings and BHT counter states.
package riscv_pkg;

   localparam logic [2:0] FNC_BEQ  = 3'b000;
   localparam logic [2:0] FNC_BNE  = 3'b001;
   localparam logic [2:0] FNC_BLT  = 3'b100;
   localparam logic [2:0] FNC_BGE  = 3'b101;
   localparam logic [2:0] FNC_BLTU = 3'b110;
   localparam logic [2:0] FNC_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_t;

   localparam bht_ctr_t BHT_RESET = WNT;

   function automatic bht_ctr_t bht_next(bht_ctr_t c, logic taken);
      bht_ctr_t n;
      n = c;
      if (taken && c != ST)
         n = bht_ctr_t'(c + 2'd1);
      else if (!taken && c != SNT)
         n = bht_ctr_t'(c - 2'd1);
      return n;
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage branch bundle and the redirect it produces.
// master = pipeline side, slave = resolver side.
interface branch_resolver_if;

   logic        ex_valid;
   logic        ex_is_branch;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        illegal_branch;

   modport master (
      output ex_valid, ex_is_branch, ex_funct3,
      output ex_pc, ex_target, ex_pred_taken,
      input  redirect_valid, redirect_pc,
      input  flush, illegal_branch
   );

   modport slave (
      input  ex_valid, ex_is_branch, ex_funct3,
      input  ex_pc, ex_target, ex_pred_taken,
      output redirect_valid, redirect_pc,
      output flush, illegal_branch
   );

endinterface

// File: rtl/bht_2bit.sv
// 2-bit saturating branch history table.
// Async read for fetch, one saturating write per cycle.
module bht_2bit
   import riscv_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_BITS-1:0] rd_idx,
   output bht_ctr_t            rd_ctr,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_taken
);

   localparam int N = 1 << IDX_BITS;

   bht_ctr_t tbl [N];

   // no bypass: a same-cycle write is seen next cycle
   assign rd_ctr = tbl[rd_idx];

   // counter array with saturating train on resolve
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++)
            tbl[i] <= BHT_RESET;
      end else if (wr_en) begin
         tbl[wr_idx] <= bht_next(tbl[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: decision, redirect,
// BHT training and branch statistics.
module branch_resolver
   import riscv_pkg::*;
#(
   parameter int BHT_IDX_BITS = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        if_pc,
   output logic               if_pred_taken,
   branch_resolver_if.slave   bus,
   output logic               brun,
   input  logic               breq,
   input  logic               brlt,
   output logic [31:0]        branch_count,
   output logic [31:0]        mispredict_count
);

   logic        resolve;
   logic        legal;
   logic        taken;
   logic        upd;
   logic        mispredict;
   logic [31:0] next_pc;
   bht_ctr_t    pred_ctr;
   logic        unused_pc;

   assign unused_pc = ^{if_pc[31:BHT_IDX_BITS+2], if_pc[1:0]};

   assign resolve = bus.ex_valid & bus.ex_is_branch;
   assign brun    = bus.ex_funct3[2] & bus.ex_funct3[1];

   // funct3 decode into taken / legal
   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      unique case (1'b1)
         (bus.ex_funct3 == FNC_BEQ):  taken = breq;
         (bus.ex_funct3 == FNC_BNE):  taken = !breq;
         (bus.ex_funct3 == FNC_BLT):  taken = brlt;
         (bus.ex_funct3 == FNC_BLTU): taken = brlt;
         (bus.ex_funct3 == FNC_BGE):  taken = !brlt;
         (bus.ex_funct3 == FNC_BGEU): taken = !brlt;
         default:                     legal = 1'b0;
      endcase
   end

   assign upd        = resolve & legal;
   assign mispredict = upd & (taken != bus.ex_pred_taken);
   assign next_pc    = taken ? bus.ex_target
                             : bus.ex_pc + 32'd4;

   bht_2bit #(.IDX_BITS(BHT_IDX_BITS)) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (if_pc[BHT_IDX_BITS+1:2]),
      .rd_ctr   (pred_ctr),
      .wr_en    (upd),
      .wr_idx   (bus.ex_pc[BHT_IDX_BITS+1:2]),
      .wr_taken (taken)
   );

   assign if_pred_taken = pred_ctr[1];

   // registered redirect, flush and illegal pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.redirect_valid <= 1'b0;
         bus.flush          <= 1'b0;
         bus.illegal_branch <= 1'b0;
         bus.redirect_pc    <= '0;
      end else begin
         bus.redirect_valid <= mispredict;
         bus.flush          <= mispredict;
         bus.illegal_branch <= resolve & !legal;
         if (mispredict)
            bus.redirect_pc <= next_pc;
      end
   end

   // wrapping branch / mispredict statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (upd)
            branch_count <= branch_count + 32'd1;
         if (mispredict)
            mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver with a behavioural
// branch comparator driven by the DUT's brun.
module tb_branch_resolver;

   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        brun;
   logic        breq;
   logic        brlt;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;
   logic [31:0] rs1;
   logic [31:0] rs2;

   always #5 clk = ~clk;

   branch_resolver_if bus();

   branch_resolver #(.BHT_IDX_BITS(6)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .bus              (bus),
      .brun             (brun),
      .breq             (breq),
      .brlt             (brlt),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   assign breq = (rs1 == rs2);
   assign brlt = brun ? (rs1 < rs2)
                      : ($signed(rs1) < $signed(rs2));

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        ill;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
         chk("flush", 32'(bus.flush), 32'(e.rv));
         chk("redirect_pc", bus.redirect_pc, e.rpc);
         chk("illegal_branch", 32'(bus.illegal_branch), 32'(e.ill));
         chk("branch_count", branch_count, e.bc);
         chk("mispredict_count", mispredict_count, e.mc);
      end
   end

   task automatic drive(input logic v, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred,
                        input logic [31:0] a, input logic [31:0] b);
      bus.ex_valid      = v;
      bus.ex_is_branch  = 1'b1;
      bus.ex_funct3     = f3;
      bus.ex_pc         = pc;
      bus.ex_target     = tgt;
      bus.ex_pred_taken = pred;
      rs1               = a;
      rs2               = b;
   endtask

   task automatic issue(input logic v, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic xbrun, input logic xpred,
                        input logic xrv, input logic [31:0] xrpc,
                        input logic xill,
                        input logic [31:0] xbc, input logic [31:0] xmc);
      @(negedge clk);
      drive(v, f3, pc, tgt, pred, a, b);
      q.push_back('{xrv, xrpc, xill, xbc, xmc});
      #1;
      chk("brun", 32'(brun), 32'(xbrun));
      chk("if_pred_taken", 32'(if_pred_taken), 32'(xpred));
   endtask

   localparam logic [31:0] NEG10 = 32'hFFFF_FFF6;

   initial begin
      rst_n = 1'b0;
      if_pc = 32'h80;
      drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      #12;
      chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst redirect_pc", bus.redirect_pc, 32'd0);
      chk("rst branch_count", branch_count, 32'd0);
      chk("rst if_pred_taken", 32'(if_pred_taken), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // v  f3      pc          tgt        pr a      b      brun pr rv rpc          il bc  mc
      issue(1, 3'b000, 32'h0,       32'h100, 0, NEG10, NEG10, 0, 0, 1, 32'h100,     0, 1,  1);
      issue(1, 3'b110, 32'h40,      32'h200, 1, NEG10, 32'd10, 1, 0, 1, 32'h44,     0, 2,  2);
      issue(1, 3'b100, 32'h40,      32'h200, 1, NEG10, 32'd10, 0, 0, 0, 32'h44,     0, 3,  2);
      issue(1, 3'b001, 32'h8,       32'h120, 0, 32'd1, 32'd2,  0, 0, 1, 32'h120,    0, 4,  3);
      issue(1, 3'b101, 32'hC,       32'h140, 1, NEG10, 32'd10, 0, 0, 1, 32'h10,     0, 5,  4);
      issue(1, 3'b111, 32'h10,      32'h160, 1, NEG10, 32'd10, 1, 0, 0, 32'h10,     0, 6,  4);
      issue(1, 3'b001, 32'hFFFFFFFC, 32'h4,  1, 32'd7, 32'd7,  0, 0, 1, 32'h0,      0, 7,  5);
      issue(0, 3'b000, 32'h80,      32'h300, 0, 32'd0, 32'd1,  0, 0, 0, 32'h0,      0, 7,  5);
      // saturation on index 32
      issue(1, 3'b000, 32'h80,      32'h300, 0, 32'd5, 32'd5,  0, 0, 1, 32'h300,    0, 8,  6);
      issue(1, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd5,  0, 1, 0, 32'h300,    0, 9,  6);
      issue(1, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd5,  0, 1, 0, 32'h300,    0, 10, 6);
      issue(1, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd5,  0, 1, 0, 32'h300,    0, 11, 6);
      issue(1, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd6,  0, 1, 1, 32'h84,     0, 12, 7);
      issue(0, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd6,  0, 1, 0, 32'h84,     0, 12, 7);
      // illegal funct3 leaves entry at weakly taken
      issue(1, 3'b010, 32'h80,      32'h300, 1, 32'd5, 32'd5,  0, 1, 0, 32'h84,     1, 12, 7);
      issue(0, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd6,  0, 1, 0, 32'h84,     0, 12, 7);
      issue(1, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd6,  0, 1, 1, 32'h84,     0, 13, 8);
      issue(0, 3'b000, 32'h80,      32'h300, 1, 32'd5, 32'd6,  0, 0, 0, 32'h84,     0, 13, 8);
      issue(1, 3'b000, 32'h0,       32'h100, 0, 32'd3, 32'd3,  0, 0, 1, 32'h100,    0, 14, 9);

      // reset asserted with a resolve in flight
      @(negedge clk);
      drive(1'b1, 3'b000, 32'h80, 32'h500, 1'b0, 32'd9, 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("mid flush", 32'(bus.flush), 32'd0);
      chk("mid illegal_branch", 32'(bus.illegal_branch), 32'd0);
      chk("mid redirect_pc", bus.redirect_pc, 32'd0);
      chk("mid branch_count", branch_count, 32'd0);
      chk("mid mispredict_count", mispredict_count, 32'd0);
      for (int i = 0; i < 64; i++) begin
         if_pc = 32'(i) << 2;
         #1;
         chk("mid if_pred_taken", 32'(if_pred_taken), 32'd0);
      end
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h80, 32'h500, 1'b0, 32'd9, 32'd9);
      if_pc = 32'h80;
      #1;
      rst_n = 1'b1;

      issue(0, 3'b000, 32'h80,      32'h500, 0, 32'd9, 32'd9,  0, 0, 0, 32'h0,      0, 0,  0);
      issue(1, 3'b001, 32'h80,      32'h500, 0, 32'd1, 32'd2,  0, 0, 1, 32'h500,    0, 1,  1);
      issue(0, 3'b000, 32'h80,      32'h500, 0, 32'd1, 32'd2,  0, 1, 0, 32'h500,    0, 1,  1);

      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d entries left, 0 required", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit for the RISC-V CPU, the consumer end of the branch comparator. It drives `brun` into `branch_comp` from the branch funct3 and turns the returned `breq`/`brlt` into a taken/not-taken decision. It compares that decision against the fetch-stage prediction and issues a registered redirect plus flush on a mispredict. It also owns the 2-bit saturating branch history table (BHT) that fetch reads for predictions, and keeps branch and mispredict statistics counters.

## Interface
- `BHT_IDX_BITS`, 6: BHT index width; table has 2^BHT_IDX_BITS entries, indexed by pc[BHT_IDX_BITS+1:2].
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_pc`  in  32  fetch PC for prediction lookup.
- `if_pred_taken`  out  1  combinational: MSB of BHT[if_pc index].
- `ex_valid`  in  1  instruction in EX is valid.
- `ex_is_branch`  in  1  instruction in EX is a conditional branch (opcode 1100011).
- `ex_funct3`  in  3  branch funct3.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_target`  in  32  computed branch target (pc + imm).
- `ex_pred_taken`  in  1  prediction carried down the pipe from fetch.
- `brun`  out  1  combinational to branch_comp: 1 for funct3 110/111, else 0.
- `breq`  in  1  from branch_comp.
- `brlt`  in  1  from branch_comp (signedness per `brun`).
- `redirect_valid`  out  1  registered; one-cycle pulse on a mispredict.
- `redirect_pc`  out  32  registered; correct next PC, held until the next redirect.
- `flush`  out  1  registered; equal to `redirect_valid`.
- `illegal_branch`  out  1  registered; one-cycle pulse on a branch with funct3 010/011.
- `branch_count`  out  32  resolved legal branches.
- `mispredict_count`  out  32  mispredicted legal branches.

## Operation
- A resolve event is `ex_valid & ex_is_branch`.
- Taken decision by funct3:
  - 000 BEQ: `breq`.
  - 001 BNE: `!breq`.
  - 100 BLT and 110 BLTU: `brlt`.
  - 101 BGE and 111 BGEU: `!brlt`.
  - 010 and 011: illegal.
- Legal resolve:
  - actual != `ex_pred_taken` is a mispredict.
  - `redirect_pc` = `ex_target` if taken, else `ex_pc + 4` (mod 2^32).
- BHT update on a legal resolve: increment the entry if taken, decrement if not; saturate at 00 and 11.
- Illegal resolve: pulse `illegal_branch`; no BHT update, no redirect, no counter change.
- Counters: `branch_count` increments on each legal resolve; `mispredict_count` increments on each mispredict. Both wrap modulo 2^32.
- Non-branch or invalid cycle: no state change; pulses deassert.

## Timing
- `brun` and `if_pred_taken` are combinational, with zero latency.
- Redirect, flush, illegal pulse, BHT write and counter updates all land on the rising edge that samples the resolve event. Outputs are visible the following cycle.
- Same-cycle BHT read and write to the same index: `if_pred_taken` returns the pre-update value; there is no bypass.
- Back-to-back resolve events every cycle are supported. Each produces an independent pulse.
- Reset (async assert, mid-operation included):
  - all BHT entries = 01 (weakly not-taken);
  - `redirect_valid`, `flush`, `illegal_branch` = 0;
  - `redirect_pc` = 0;
  - counters = 0.
  - A resolve in flight at reset is dropped.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants `FNC_BEQ` … `FNC_BGEU`;
  - BHT counter states `SNT`=00, `WNT`=01, `WT`=10, `ST`=11;
  - `BHT_RESET` = `WNT`.
- Sub-module `bht_2bit`: holds the counter array; one async read port, one write port with saturating update, and async reset.
- The `branch_resolver` top contains the decision logic, redirect registers and counters.

## Test plan
- BEQ, rs1 = rs2 = 0xFFFFFFF6, pred 0:
  - `brun`=0, taken;
  - next cycle `redirect_valid`=1, `redirect_pc`=`ex_target`=0x100;
  - `mispredict_count`=1.
- BLTU, rs1 = 0xFFFFFFF6, rs2 = 10, pc 0x40, pred 1:
  - `brun`=1, `brlt`=0, not taken;
  - `redirect_pc`=0x44.
- BLT, same operands, pred 1: `brun`=0, taken, no redirect; `branch_count`+1.
- Saturation, pc 0x80 (index 32): resolve taken 4 times.
  - `if_pred_taken` for 0x80 goes 0 → 1 after the first update;
  - the entry stays at 11;
  - one not-taken resolve leaves prediction 1.
- funct3 010 with `ex_valid`=1:
  - `illegal_branch` pulses;
  - counters and the BHT entry are unchanged;
  - no redirect.
- Assert `rst_n`=0 mid-stream, after redirects:
  - all outputs are 0 immediately;
  - `if_pred_taken`=0 for every index.
